// File: rtl/rec_frame_seq_if.sv
// ----------------------------------------------------------------------------
// rec_frame_seq_if
// Groups the byte-link input, the CRC engine handshake, the commit bus and
// the status counters of rec_frame_seq. Signal names match the original
// flat port list so existing connections map one-to-one.
//   slave  : seen by rec_frame_seq (receives i_*, drives o_*)
//   master : seen by the surrounding logic / testbench
// ----------------------------------------------------------------------------
interface rec_frame_seq_if #(
    parameter int unsigned MAX_LEN = 32
) ();
    logic [7:0]           i_byte;
    logic                 i_byte_valid;
    logic [15:0]          i_crc;
    logic                 o_crc_init;
    logic [7:0]           o_crc_din;
    logic                 o_crc_din_vld;
    logic                 o_wr_en;
    logic [7:0]           o_wr_id;
    logic [5:0]           o_wr_len;
    logic [8*MAX_LEN-1:0] o_wr_data;
    logic                 o_busy;
    logic [15:0]          o_ok_cnt;
    logic [15:0]          o_crc_err_cnt;
    logic [15:0]          o_len_err_cnt;
    logic [15:0]          o_tmo_cnt;

    modport slave (
        input  i_byte, i_byte_valid, i_crc,
        output o_crc_init, o_crc_din, o_crc_din_vld,
        output o_wr_en, o_wr_id, o_wr_len, o_wr_data, o_busy,
        output o_ok_cnt, o_crc_err_cnt, o_len_err_cnt, o_tmo_cnt
    );

    modport master (
        output i_byte, i_byte_valid, i_crc,
        input  o_crc_init, o_crc_din, o_crc_din_vld,
        input  o_wr_en, o_wr_id, o_wr_len, o_wr_data, o_busy,
        input  o_ok_cnt, o_crc_err_cnt, o_len_err_cnt, o_tmo_cnt
    );
endinterface

// File: rtl/rec_frame_seq.sv
// ----------------------------------------------------------------------------
// rec_frame_seq
// Control-link frame receiver: HDR(2) ID LEN PAYLOAD(LEN) CRC_H CRC_L.
// ID, LEN and payload bytes are forwarded to an external CRC16 engine; the
// received CRC is compared against the engine result and a good frame is
// committed on the o_wr_* bus. Bad length, bad CRC and inter-byte timeout
// are counted in saturating 16-bit counters.
// Ports:
//   i_clk163m84 : sole clock
//   i_rst_n     : asynchronous active-low reset
//   bus         : rec_frame_seq_if.slave (byte input, CRC engine, commit, stats)
// ----------------------------------------------------------------------------
module rec_frame_seq #(
    parameter logic [15:0] HDR         = 16'hEB90,
    parameter int unsigned MAX_LEN     = 32,
    parameter int unsigned TIMEOUT_CYC = 4096
) (
    input logic             i_clk163m84,
    input logic             i_rst_n,
    rec_frame_seq_if.slave  bus
);
    localparam int unsigned   GW       = $clog2(TIMEOUT_CYC);
    localparam logic [GW-1:0] GAP_LAST = GW'(TIMEOUT_CYC - 1);

    typedef enum logic [2:0] {
        ST_IDLE, ST_HDR2, ST_ID, ST_LEN, ST_PAYLOAD, ST_CRC_H, ST_CRC_L, ST_CHECK
    } state_t;

    state_t               state_q, state_d;
    logic [GW-1:0]        gap_q, gap_d;
    logic [7:0]           id_q, id_d;
    logic [5:0]           len_q, len_d;
    logic [5:0]           idx_q, idx_d;
    logic [15:0]          crc_rx_q, crc_rx_d;
    logic [8*MAX_LEN-1:0] payload_q, payload_d;
    logic                 crc_init_q, crc_init_d;
    logic [7:0]           crc_din_q, crc_din_d;
    logic                 crc_din_vld_q, crc_din_vld_d;
    logic                 wr_en_q, wr_en_d;
    logic [7:0]           wr_id_q, wr_id_d;
    logic [5:0]           wr_len_q, wr_len_d;
    logic [8*MAX_LEN-1:0] wr_data_q, wr_data_d;
    logic [15:0]          ok_cnt_q, ok_cnt_d;
    logic [15:0]          crc_err_cnt_q, crc_err_cnt_d;
    logic [15:0]          len_err_cnt_q, len_err_cnt_d;
    logic [15:0]          tmo_cnt_q, tmo_cnt_d;
    logic                 counting;
    logic                 timeout;

    function automatic logic [15:0] sat_inc(input logic [15:0] v);
        return (v == 16'hFFFF) ? v : v + 16'd1;
    endfunction

    always_comb begin
        state_d       = state_q;
        gap_d         = gap_q;
        id_d          = id_q;
        len_d         = len_q;
        idx_d         = idx_q;
        crc_rx_d      = crc_rx_q;
        payload_d     = payload_q;
        crc_init_d    = 1'b0;
        crc_din_d     = crc_din_q;
        crc_din_vld_d = 1'b0;
        wr_en_d       = 1'b0;
        wr_id_d       = wr_id_q;
        wr_len_d      = wr_len_q;
        wr_data_d     = wr_data_q;
        ok_cnt_d      = ok_cnt_q;
        crc_err_cnt_d = crc_err_cnt_q;
        len_err_cnt_d = len_err_cnt_q;
        tmo_cnt_d     = tmo_cnt_q;

        counting = (state_q != ST_IDLE) && (state_q != ST_CHECK);
        timeout  = counting && (gap_q == GAP_LAST);
        if (counting) gap_d = gap_q + 1'b1;

        // Timeout and CHECK both win over a coincident byte, which is dropped.
        if (timeout) begin
            state_d   = ST_IDLE;
            gap_d     = '0;
            tmo_cnt_d = sat_inc(tmo_cnt_q);
        end else if (state_q == ST_CHECK) begin
            state_d = ST_IDLE;
            gap_d   = '0;
            if (crc_rx_q == bus.i_crc) begin
                wr_en_d   = 1'b1;
                wr_id_d   = id_q;
                wr_len_d  = len_q;
                wr_data_d = payload_q;
                ok_cnt_d  = sat_inc(ok_cnt_q);
            end else begin
                crc_err_cnt_d = sat_inc(crc_err_cnt_q);
            end
        end else if (bus.i_byte_valid) begin
            gap_d = '0;
            unique case (state_q)
                ST_IDLE: begin
                    if (bus.i_byte == HDR[15:8]) state_d = ST_HDR2;
                end
                ST_HDR2: begin
                    if (bus.i_byte == HDR[7:0]) begin
                        state_d    = ST_ID;
                        crc_init_d = 1'b1;
                    end else if (bus.i_byte != HDR[15:8]) begin
                        state_d = ST_IDLE;
                    end
                end
                ST_ID: begin
                    id_d          = bus.i_byte;
                    crc_din_d     = bus.i_byte;
                    crc_din_vld_d = 1'b1;
                    state_d       = ST_LEN;
                end
                ST_LEN: begin
                    crc_din_d     = bus.i_byte;
                    crc_din_vld_d = 1'b1;
                    if ((bus.i_byte != 8'd0) && (32'(bus.i_byte) <= MAX_LEN)) begin
                        len_d     = 6'(bus.i_byte);
                        idx_d     = '0;
                        payload_d = '0;
                        state_d   = ST_PAYLOAD;
                    end else begin
                        len_err_cnt_d = sat_inc(len_err_cnt_q);
                        state_d       = ST_IDLE;
                    end
                end
                ST_PAYLOAD: begin
                    crc_din_d     = bus.i_byte;
                    crc_din_vld_d = 1'b1;
                    for (int unsigned k = 0; k < MAX_LEN; k++) begin
                        if (idx_q == 6'(k)) payload_d[8*k +: 8] = bus.i_byte;
                    end
                    if (idx_q == len_q - 6'd1) state_d = ST_CRC_H;
                    else                       idx_d   = idx_q + 6'd1;
                end
                ST_CRC_H: begin
                    crc_rx_d[15:8] = bus.i_byte;
                    state_d        = ST_CRC_L;
                end
                ST_CRC_L: begin
                    crc_rx_d[7:0] = bus.i_byte;
                    state_d       = ST_CHECK;
                end
                default: state_d = ST_IDLE;
            endcase
        end
    end

    always_ff @(posedge i_clk163m84 or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_q       <= ST_IDLE;
            gap_q         <= '0;
            id_q          <= '0;
            len_q         <= '0;
            idx_q         <= '0;
            crc_rx_q      <= '0;
            payload_q     <= '0;
            crc_init_q    <= 1'b0;
            crc_din_q     <= '0;
            crc_din_vld_q <= 1'b0;
            wr_en_q       <= 1'b0;
            wr_id_q       <= '0;
            wr_len_q      <= '0;
            wr_data_q     <= '0;
            ok_cnt_q      <= '0;
            crc_err_cnt_q <= '0;
            len_err_cnt_q <= '0;
            tmo_cnt_q     <= '0;
        end else begin
            state_q       <= state_d;
            gap_q         <= gap_d;
            id_q          <= id_d;
            len_q         <= len_d;
            idx_q         <= idx_d;
            crc_rx_q      <= crc_rx_d;
            payload_q     <= payload_d;
            crc_init_q    <= crc_init_d;
            crc_din_q     <= crc_din_d;
            crc_din_vld_q <= crc_din_vld_d;
            wr_en_q       <= wr_en_d;
            wr_id_q       <= wr_id_d;
            wr_len_q      <= wr_len_d;
            wr_data_q     <= wr_data_d;
            ok_cnt_q      <= ok_cnt_d;
            crc_err_cnt_q <= crc_err_cnt_d;
            len_err_cnt_q <= len_err_cnt_d;
            tmo_cnt_q     <= tmo_cnt_d;
        end
    end

    assign bus.o_crc_init    = crc_init_q;
    assign bus.o_crc_din     = crc_din_q;
    assign bus.o_crc_din_vld = crc_din_vld_q;
    assign bus.o_wr_en       = wr_en_q;
    assign bus.o_wr_id       = wr_id_q;
    assign bus.o_wr_len      = wr_len_q;
    assign bus.o_wr_data     = wr_data_q;
    assign bus.o_busy        = (state_q != ST_IDLE);
    assign bus.o_ok_cnt      = ok_cnt_q;
    assign bus.o_crc_err_cnt = crc_err_cnt_q;
    assign bus.o_len_err_cnt = len_err_cnt_q;
    assign bus.o_tmo_cnt     = tmo_cnt_q;
endmodule

// File: tb/tb_rec_frame_seq.sv
module tb_rec_frame_seq;
    logic clk;
    logic rst_n;

    rec_frame_seq_if #(.MAX_LEN(32)) bus ();

    rec_frame_seq #(
        .HDR(16'hEB90),
        .MAX_LEN(32),
        .TIMEOUT_CYC(4096)
    ) dut (
        .i_clk163m84(clk),
        .i_rst_n(rst_n),
        .bus(bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct packed {
        logic [7:0]   id;
        logic [5:0]   len;
        logic [255:0] data;
    } commit_t;

    commit_t exp_q[$];
    int checks = 0;
    int errors = 0;
    int init_pulses = 0;
    int vld_pulses = 0;
    logic [15:0] crc_eng;
    logic        wr_en_prev = 1'b0;

    function automatic logic [15:0] crc_upd(input logic [15:0] c, input logic [7:0] d);
        logic [15:0] r;
        r = c ^ {d, 8'h00};
        for (int i = 0; i < 8; i++) r = r[15] ? ((r << 1) ^ 16'h1021) : (r << 1);
        return r;
    endfunction

    // CRC16-CCITT engine model driven by the DUT's CRC handshake.
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n)                 crc_eng <= 16'hFFFF;
        else if (bus.o_crc_init)    crc_eng <= 16'hFFFF;
        else if (bus.o_crc_din_vld) crc_eng <= crc_upd(crc_eng, bus.o_crc_din);
    end
    assign bus.i_crc = crc_eng;

    // Scoreboard monitor.
    always @(negedge clk) begin
        if (rst_n) begin
            if (bus.o_crc_init)    init_pulses++;
            if (bus.o_crc_din_vld) vld_pulses++;
            if (bus.o_wr_en) begin
                checks++;
                if (wr_en_prev) begin
                    errors++;
                    $display("FAIL wr_en_width: o_wr_en high two cycles in a row, required one-cycle pulse");
                end else if (exp_q.size() == 0) begin
                    errors++;
                    $display("FAIL unexpected_commit: id=%h len=%0d data=%h, required no commit",
                             bus.o_wr_id, bus.o_wr_len, bus.o_wr_data);
                end else begin
                    commit_t e;
                    e = exp_q.pop_front();
                    if (bus.o_wr_id !== e.id || bus.o_wr_len !== e.len || bus.o_wr_data !== e.data) begin
                        errors++;
                        $display("FAIL commit: got id=%h len=%0d data=%h, required id=%h len=%0d data=%h",
                                 bus.o_wr_id, bus.o_wr_len, bus.o_wr_data, e.id, e.len, e.data);
                    end
                end
            end
        end
        wr_en_prev = rst_n && bus.o_wr_en;
    end

    task automatic chk(input string name, input logic [255:0] act, input logic [255:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got %h, required %h", name, act, req);
        end
    endtask

    task automatic send_byte(input logic [7:0] b);
        @(negedge clk);
        bus.i_byte       = b;
        bus.i_byte_valid = 1'b1;
        @(negedge clk);
        bus.i_byte_valid = 1'b0;
    endtask

    task automatic idle(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic send_frame(input logic [7:0] id, input logic [7:0] len,
                              input logic [255:0] data, input logic [15:0] crc_flip);
        logic [15:0] c;
        c = 16'hFFFF;
        send_byte(8'hEB);
        send_byte(8'h90);
        send_byte(id);  c = crc_upd(c, id);
        send_byte(len); c = crc_upd(c, len);
        for (int k = 0; k < int'(len); k++) begin
            send_byte(data[8*k +: 8]);
            c = crc_upd(c, data[8*k +: 8]);
        end
        c = c ^ crc_flip;
        send_byte(c[15:8]);
        send_byte(c[7:0]);
        idle(4);
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, "_wr_en"},   256'(bus.o_wr_en), 256'd0);
        chk({tag, "_wr_id"},   256'(bus.o_wr_id), 256'd0);
        chk({tag, "_wr_len"},  256'(bus.o_wr_len), 256'd0);
        chk({tag, "_wr_data"}, bus.o_wr_data, 256'd0);
        chk({tag, "_busy"},    256'(bus.o_busy), 256'd0);
        chk({tag, "_init"},    256'(bus.o_crc_init), 256'd0);
        chk({tag, "_din_vld"}, 256'(bus.o_crc_din_vld), 256'd0);
        chk({tag, "_din"},     256'(bus.o_crc_din), 256'd0);
        chk({tag, "_ok"},      256'(bus.o_ok_cnt), 256'd0);
        chk({tag, "_crcerr"},  256'(bus.o_crc_err_cnt), 256'd0);
        chk({tag, "_lenerr"},  256'(bus.o_len_err_cnt), 256'd0);
        chk({tag, "_tmo"},     256'(bus.o_tmo_cnt), 256'd0);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached, required completion");
        $fatal(1, "watchdog");
    end

    initial begin
        int i0, v0;
        logic [15:0] c;
        rst_n            = 1'b0;
        bus.i_byte       = 8'h00;
        bus.i_byte_valid = 1'b0;
        idle(3);
        chk_all_zero("reset");
        rst_n = 1'b1;
        idle(1);

        // Basic good frame.
        v0 = vld_pulses;
        exp_q.push_back('{id: 8'h16, len: 6'd2, data: 256'h5AA5});
        send_frame(8'h16, 8'h02, 256'h5AA5, 16'h0000);
        chk("ok_cnt_1", 256'(bus.o_ok_cnt), 256'd1);
        chk("vld_good", 256'(vld_pulses - v0), 256'd4);
        chk("busy_after_good", 256'(bus.o_busy), 256'd0);

        // Same frame, CRC low byte flipped: no commit, outputs held.
        send_frame(8'h16, 8'h02, 256'h5AA5, 16'h00FF);
        chk("crc_err_1", 256'(bus.o_crc_err_cnt), 256'd1);
        chk("ok_cnt_held", 256'(bus.o_ok_cnt), 256'd1);
        chk("wr_id_held", 256'(bus.o_wr_id), 256'h16);
        chk("wr_len_held", 256'(bus.o_wr_len), 256'd2);
        chk("wr_data_held", bus.o_wr_data, 256'h5AA5);

        // Header resync EB EB 90; payload buffer must be cleared (old 5A gone).
        i0 = init_pulses;
        c = crc_upd(crc_upd(crc_upd(16'hFFFF, 8'h01), 8'h01), 8'h33);
        exp_q.push_back('{id: 8'h01, len: 6'd1, data: 256'h33});
        send_byte(8'hEB); send_byte(8'hEB); send_byte(8'h90);
        send_byte(8'h01); send_byte(8'h01); send_byte(8'h33);
        send_byte(c[15:8]); send_byte(c[7:0]);
        idle(4);
        chk("resync_init_once", 256'(init_pulses - i0), 256'd1);
        chk("ok_cnt_2", 256'(bus.o_ok_cnt), 256'd2);

        // Length errors: 00 and 21h.
        v0 = vld_pulses;
        send_byte(8'hEB); send_byte(8'h90); send_byte(8'h07); send_byte(8'h00);
        send_byte(8'hEB); send_byte(8'h90); send_byte(8'h07); send_byte(8'h21);
        idle(3);
        chk("len_err_2", 256'(bus.o_len_err_cnt), 256'd2);
        chk("busy_len_err", 256'(bus.o_busy), 256'd0);
        chk("vld_len_err", 256'(vld_pulses - v0), 256'd4);

        // Maximum length accepted.
        exp_q.push_back('{id: 8'hC3, len: 6'd32,
                          data: 256'h201F1E1D1C1B1A191817161514131211100F0E0D0C0B0A090807060504030201});
        send_frame(8'hC3, 8'd32,
                   256'h201F1E1D1C1B1A191817161514131211100F0E0D0C0B0A090807060504030201, 16'h0000);
        chk("ok_cnt_3", 256'(bus.o_ok_cnt), 256'd3);

        // Timeout after 3 of 4 payload bytes, then a good frame.
        send_byte(8'hEB); send_byte(8'h90); send_byte(8'h05); send_byte(8'h04);
        send_byte(8'h11); send_byte(8'h22); send_byte(8'h33);
        chk("busy_stalled", 256'(bus.o_busy), 256'd1);
        idle(4200);
        chk("tmo_cnt_1", 256'(bus.o_tmo_cnt), 256'd1);
        chk("busy_after_tmo", 256'(bus.o_busy), 256'd0);
        exp_q.push_back('{id: 8'h09, len: 6'd3, data: 256'h030201});
        send_frame(8'h09, 8'h03, 256'h030201, 16'h0000);
        chk("ok_cnt_4", 256'(bus.o_ok_cnt), 256'd4);

        // CRC error counter saturation.
        @(negedge clk);
        force dut.crc_err_cnt_q = 16'hFFFE;
        @(negedge clk);
        release dut.crc_err_cnt_q;
        send_frame(8'h16, 8'h02, 256'h5AA5, 16'h00FF);
        chk("crc_err_ffff", 256'(bus.o_crc_err_cnt), 256'hFFFF);
        send_frame(8'h16, 8'h02, 256'h5AA5, 16'h00FF);
        chk("crc_err_sat", 256'(bus.o_crc_err_cnt), 256'hFFFF);

        // Reset mid-PAYLOAD.
        send_byte(8'hEB); send_byte(8'h90); send_byte(8'h44); send_byte(8'h05);
        send_byte(8'h01); send_byte(8'h02);
        chk("busy_mid_payload", 256'(bus.o_busy), 256'd1);
        @(posedge clk);
        #2 rst_n = 1'b0;
        #1 chk_all_zero("midreset");
        idle(2);
        rst_n = 1'b1;
        idle(1);
        chk("busy_post_reset", 256'(bus.o_busy), 256'd0);

        // Receiver works after reset.
        exp_q.push_back('{id: 8'h5E, len: 6'd1, data: 256'hA7});
        send_frame(8'h5E, 8'h01, 256'hA7, 16'h0000);
        chk("ok_cnt_post_reset", 256'(bus.o_ok_cnt), 256'd1);
        chk("scoreboard_empty", 256'(exp_q.size()), 256'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
